// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_sequencer
// Purpose  : Command/response front end and power sequencer for a 16-bit power-gated ALU
// Revision : 1.0
// ============================================================================
module alu_cmd_sequencer #(
   parameter int          PWR_SETTLE   = 4,
   parameter int          IDLE_TIMEOUT = 64,
   parameter int          WDOG_CYCLES  = 32,
   parameter logic [15:0] CLAMP_VAL    = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_opcode,
   input  logic [15:0] cmd_a,
   input  logic [15:0] cmd_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_data,
   output logic        rsp_err,
   output logic        alu_pwr_en,
   output logic        iso_en,
   output logic        alu_start,
   output logic [3:0]  alu_opcode,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [15:0] clamp_value,
   input  logic [15:0] alu_result,
   input  logic        alu_busy,
   output logic        pwr_on
);

   localparam int c_SW = (PWR_SETTLE > 1) ? $clog2(PWR_SETTLE) : 1;
   localparam int c_IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
   localparam int c_WW = $clog2(WDOG_CYCLES);
   localparam logic [c_SW-1:0] c_SETTLE_LAST = c_SW'(PWR_SETTLE - 1);
   localparam logic [c_IW-1:0] c_IDLE_LAST   = c_IW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
   localparam logic [c_WW-1:0] c_WDOG_LAST   = c_WW'(WDOG_CYCLES - 1);
   localparam bit              c_IDLE_EN     = (IDLE_TIMEOUT > 0);

   typedef enum logic [2:0] {
      S_OFF    = 3'd0,
      S_PWR_UP = 3'd1,
      S_READY  = 3'd2,
      S_ISSUE  = 3'd3,
      S_WAIT   = 3'd4,
      S_RESP   = 3'd5,
      S_ISO_ON = 3'd6
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [c_SW-1:0]   r_settle;
   logic [c_IW-1:0]   r_idle;
   logic [c_WW-1:0]   r_wdog;
   logic              r_abort;
   logic [3:0]        r_op;
   logic [15:0]       r_a;
   logic [15:0]       r_b;
   logic [15:0]       r_rsp_data;
   logic              r_rsp_err;
   logic              w_accept;
   logic              w_illegal;
   logic              w_wdog_hit;

   assign w_accept   = (r_state == S_READY) && cmd_valid;
   assign w_illegal  = (cmd_opcode > 4'd9);
   assign w_wdog_hit = (r_wdog == c_WDOG_LAST);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_OFF: begin
            // An aborted command reports its error only once the ALU is dark.
            if (r_abort)        w_state_nxt = S_RESP;
            else if (cmd_valid) w_state_nxt = S_PWR_UP;
         end
         S_PWR_UP: if (r_settle == c_SETTLE_LAST) w_state_nxt = S_READY;
         S_READY: begin
            if (cmd_valid)                              w_state_nxt = w_illegal ? S_RESP : S_ISSUE;
            else if (c_IDLE_EN && r_idle == c_IDLE_LAST) w_state_nxt = S_ISO_ON;
         end
         S_ISSUE:  w_state_nxt = S_WAIT;
         S_WAIT: begin
            if (!alu_busy)       w_state_nxt = S_RESP;
            else if (w_wdog_hit) w_state_nxt = S_ISO_ON;
         end
         S_RESP:   if (rsp_ready) w_state_nxt = r_abort ? S_OFF : S_READY;
         S_ISO_ON: w_state_nxt = S_OFF;
         default:  w_state_nxt = S_OFF;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_OFF;
         r_settle   <= '0;
         r_idle     <= '0;
         r_wdog     <= '0;
         r_abort    <= 1'b0;
         r_op       <= 4'd0;
         r_a        <= 16'd0;
         r_b        <= 16'd0;
         r_rsp_data <= 16'd0;
         r_rsp_err  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_settle <= (r_state == S_PWR_UP) ? r_settle + 1'b1 : '0;
         r_idle   <= (r_state == S_READY && w_state_nxt == S_READY) ? r_idle + 1'b1 : '0;
         r_wdog   <= (r_state == S_WAIT) ? r_wdog + 1'b1 : '0;

         if (w_accept) begin
            r_op <= cmd_opcode;
            r_a  <= cmd_a;
            r_b  <= cmd_b;
            if (w_illegal) begin
               r_rsp_data <= 16'd0;
               r_rsp_err  <= 1'b1;
            end
         end

         if (r_state == S_WAIT) begin
            if (!alu_busy) begin
               r_rsp_data <= alu_result;
               r_rsp_err  <= (r_op == 4'd9) && (r_b == 16'd0);
            end else if (w_wdog_hit) begin
               r_rsp_data <= 16'd0;
               r_rsp_err  <= 1'b1;
               r_abort    <= 1'b1;
            end
         end

         if (r_state == S_RESP && rsp_ready) r_abort <= 1'b0;
      end
   end

   assign cmd_ready   = (r_state == S_READY);
   assign alu_start   = (r_state == S_ISSUE);
   assign rsp_valid   = (r_state == S_RESP);
   assign rsp_data    = r_rsp_data;
   assign rsp_err     = r_rsp_err;
   assign alu_opcode  = r_op;
   assign alu_a       = r_a;
   assign alu_b       = r_b;
   assign clamp_value = CLAMP_VAL;
   assign alu_pwr_en  = (r_state != S_OFF) && !((r_state == S_RESP) && r_abort);
   assign iso_en      = (r_state == S_OFF) || (r_state == S_PWR_UP) || (r_state == S_ISO_ON) ||
                        ((r_state == S_RESP) && r_abort);
   assign pwr_on      = (r_state == S_READY) || (r_state == S_ISSUE) ||
                        (r_state == S_WAIT)  || (r_state == S_RESP);

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_sequencer
// Purpose  : Scoreboard bench for alu_cmd_sequencer with a behavioural ALU model
// Revision : 1.0
// ============================================================================
module tb_alu_cmd_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_opcode = 4'd0;
   logic [15:0] cmd_a = 16'd0;
   logic [15:0] cmd_b = 16'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [15:0] rsp_data;
   logic        rsp_err;
   logic        alu_pwr_en;
   logic        iso_en;
   logic        alu_start;
   logic [3:0]  alu_opcode;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [15:0] clamp_value;
   logic [15:0] alu_result;
   logic        alu_busy;
   logic        pwr_on;

   alu_cmd_sequencer #(
      .PWR_SETTLE  (4),
      .IDLE_TIMEOUT(8),
      .WDOG_CYCLES (32),
      .CLAMP_VAL   (16'h0000)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_opcode (cmd_opcode),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .alu_pwr_en (alu_pwr_en),
      .iso_en     (iso_en),
      .alu_start  (alu_start),
      .alu_opcode (alu_opcode),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .clamp_value(clamp_value),
      .alu_result (alu_result),
      .alu_busy   (alu_busy),
      .pwr_on     (pwr_on)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      logic        err;
      int          lat;   // -1: latency not checked
      logic        pwr;
      int          acc;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual %0h required %0h", nm, act, req);
      end
   endtask

   // ---------------- behavioural ALU: MUL/DIV sample operands at completion
   logic [15:0] m_res = 16'd0;
   logic        m_busy = 1'b0;
   int          m_cnt = 0;
   logic [3:0]  m_op = 4'd0;
   logic [15:0] m_a_cap = 16'd0;
   logic [15:0] m_b_cap = 16'd0;
   bit          m_stuck = 1'b0;
   int          n_start = 0;

   assign alu_result = m_res;
   assign alu_busy   = m_busy;

   function automatic logic [15:0] f_simple(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return a << b[3:0];
         4'd6:    return a >> b[3:0];
         default: return ~a;
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_cnt  <= 0;
         m_res  <= 16'd0;
      end else if (!alu_pwr_en) begin
         m_busy <= 1'b0;
         m_cnt  <= 0;
      end else if (alu_start) begin
         n_start <= n_start + 1;
         m_op    <= alu_opcode;
         m_a_cap <= alu_a;
         m_b_cap <= alu_b;
         if (alu_opcode == 4'd8) begin
            m_busy <= 1'b1;
            m_cnt  <= 5;
         end else if (alu_opcode == 4'd9) begin
            m_busy <= 1'b1;
            m_cnt  <= 9;
         end else begin
            m_busy <= 1'b0;
            m_res  <= f_simple(alu_opcode, alu_a, alu_b);
         end
      end else if (m_cnt != 0 && !m_stuck) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin
            m_busy <= 1'b0;
            if (m_op == 4'd8) m_res <= alu_a * alu_b;
            else              m_res <= (alu_b == 16'd0) ? 16'd0 : alu_a / alu_b;
         end
      end
   end

   // ---------------- invariant monitor
   initial begin : p_inv
      logic p_pwr;
      logic p_iso;
      p_pwr = 1'b0;
      p_iso = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            p_pwr = 1'b0;
            p_iso = 1'b1;
         end else begin
            if (alu_start) chk("start_gated", {iso_en, alu_pwr_en}, 2'b01);
            if (p_pwr && !alu_pwr_en) chk("iso_before_pwr_off", p_iso, 1);
            if (m_cnt == 1 && m_busy && !m_stuck) chk("operand_hold", {alu_a, alu_b}, {m_a_cap, m_b_cap});
            p_pwr = alu_pwr_en;
            p_iso = iso_en;
         end
      end
   end

   // ---------------- response scoreboard monitor
   initial begin : p_mon
      exp_t cur;
      bit   seen;
      seen = 1'b0;
      cur  = '{16'd0, 1'b0, -1, 1'b1, 0};
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            seen = 1'b0;
         end else if (rsp_valid) begin
            if (!seen) begin
               seen = 1'b1;
               if (q.size() == 0) begin
                  chk("rsp_unexpected", {rsp_data, rsp_err}, 17'h1FFFF);
                  cur = '{rsp_data, rsp_err, -1, alu_pwr_en, cyc};
               end else begin
                  cur = q.pop_front();
                  chk("rsp_data", rsp_data, cur.data);
                  chk("rsp_err", rsp_err, cur.err);
                  chk("rsp_pwr_en", alu_pwr_en, cur.pwr);
                  if (cur.lat >= 0) chk("rsp_latency", cyc - cur.acc, cur.lat);
               end
            end else begin
               chk("rsp_hold", {rsp_data, rsp_err, cmd_ready}, {cur.data, cur.err, 1'b0});
            end
            if (rsp_ready) seen = 1'b0;
         end
      end
   end

   // ---------------- stimulus
   task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] ed, input logic ee, input int el, input logic ep,
                       input bit wake);
      int   settle;
      int   k;
      exp_t e;
      @(posedge clk); #1;
      cmd_valid  = 1'b1;
      cmd_opcode = op;
      cmd_a      = a;
      cmd_b      = b;
      settle     = 0;
      k          = 0;
      @(negedge clk);
      while (!cmd_ready && k < 300) begin
         if (!alu_pwr_en) settle = 0;
         else if (iso_en) settle++;
         k++;
         @(negedge clk);
      end
      if (!cmd_ready) begin
         chk("accept_timeout", 1, 0);
         @(posedge clk); #1;
         cmd_valid = 1'b0;
      end else begin
         @(posedge clk); #1;
         e = '{ed, ee, el, ep, cyc};
         q.push_back(e);
         cmd_valid = 1'b0;
         if (wake || settle != 0) chk("wake_settle", settle, 4);
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while ((q.size() != 0 || rsp_valid) && k < 200);
      if (k >= 200) chk("rsp_timeout", 1, 0);
   endtask

   initial begin : p_guard
      #100000;
      $display("FAIL global_timeout: actual running required finished");
      $fatal(1, "global timeout");
   end

   initial begin : p_stim
      int s0;
      int k;
      int idle;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", {alu_pwr_en, iso_en, alu_start, cmd_ready, rsp_valid, rsp_err, pwr_on,
                          rsp_data, alu_opcode, alu_a, alu_b}, {7'b0100000, 52'd0});
      chk("clamp_value", clamp_value, 16'h0000);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("off_idle", {alu_pwr_en, iso_en, cmd_ready, pwr_on}, 4'b0100);

      // wake from reset, then single-cycle ops and wrap-around
      s0 = n_start;
      send(4'd0, 16'd3, 16'd4, 16'd7, 1'b0, 2, 1'b1, 1'b1);
      drain();
      chk("start_count_add", n_start - s0, 1);
      send(4'd4, 16'hF0F0, 16'h0FF0, 16'hFF00, 1'b0, 2, 1'b1, 1'b0);
      send(4'd2, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 2, 1'b1, 1'b0);
      send(4'd1, 16'd3, 16'd4, 16'hFFFF, 1'b0, 2, 1'b1, 1'b0);
      send(4'd0, 16'hFFFF, 16'd1, 16'h0000, 1'b0, 2, 1'b1, 1'b0);

      // multi-cycle ops
      send(4'd8, 16'd300, 16'd300, 16'h5F90, 1'b0, 7, 1'b1, 1'b0);
      send(4'd9, 16'd100, 16'd0, 16'h0000, 1'b1, 11, 1'b1, 1'b0);
      send(4'd9, 16'd100, 16'd7, 16'd14, 1'b0, 11, 1'b1, 1'b0);
      drain();

      // illegal opcodes: no ALU issue; first one held with rsp_ready low
      s0 = n_start;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      send(4'hC, 16'd1, 16'd2, 16'h0000, 1'b1, -1, 1'b1, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      drain();
      send(4'hA, 16'd1, 16'd2, 16'h0000, 1'b1, -1, 1'b1, 1'b0);
      send(4'hF, 16'd1, 16'd2, 16'h0000, 1'b1, -1, 1'b1, 1'b0);
      drain();
      chk("start_count_illegal", n_start - s0, 0);

      // idle timeout power-down and re-wake
      send(4'd3, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 2, 1'b1, 1'b0);
      drain();
      k = 0;
      while (!cmd_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      idle = 0;
      while (cmd_ready && idle < 100) begin
         idle++;
         @(negedge clk);
      end
      chk("idle_cycles", idle, 8);
      chk("iso_on_phase", {iso_en, alu_pwr_en}, 2'b11);
      @(negedge clk);
      chk("off_phase", {iso_en, alu_pwr_en, pwr_on}, 3'b100);
      send(4'd0, 16'd1, 16'd1, 16'd2, 1'b0, 2, 1'b1, 1'b1);
      drain();

      // stuck ALU: watchdog abort, error posted after power-down
      m_stuck = 1'b1;
      send(4'd8, 16'd5, 16'd6, 16'h0000, 1'b1, 35, 1'b0, 1'b0);
      drain();
      m_stuck = 1'b0;
      send(4'd0, 16'd2, 16'd2, 16'd4, 1'b0, 2, 1'b1, 1'b1);
      drain();

      // asynchronous reset in the middle of WAIT
      m_stuck = 1'b1;
      send(4'd8, 16'd9, 16'd9, 16'h0000, 1'b0, -1, 1'b1, 1'b0);
      repeat (5) @(posedge clk);
      #3;
      chk("pre_reset_wait", {pwr_on, alu_busy, alu_a}, {1'b1, 1'b1, 16'd9});
      rst_n = 1'b0;
      #1;
      chk("async_reset", {alu_pwr_en, iso_en, alu_start, cmd_ready, rsp_valid, rsp_err, pwr_on,
                          rsp_data, alu_opcode, alu_a, alu_b}, {7'b0100000, 52'd0});
      q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n   = 1'b1;
      m_stuck = 1'b0;
      send(4'd0, 16'd5, 16'd5, 16'd10, 1'b0, 2, 1'b1, 1'b1);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
